mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: runs loads and stores over a req/ack memory port with a
// bounded wait, and produces the MEM/WB writeback bundle plus the EX-forwarding value.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [138:0] EX_MEM,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic [37:0]  MEM_WB,
  output logic [31:0]  fwd_data,
  output logic         bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  count;
  logic [31:0] rdata;

  logic [31:0] store_data;
  logic [31:0] alu_result;
  logic [4:0]  write_reg;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  mem_to_reg;
  logic [31:0] pc_plus4;
  logic [31:0] lu_data;
  logic        lu_op;
  logic        access;
  logic [31:0] wb_data;

  logic        issue;
  logic        ack_seen;
  logic        timed_out;

  assign store_data = EX_MEM[31:0];
  assign alu_result = EX_MEM[63:32];
  assign write_reg  = EX_MEM[68:64];
  assign mem_read   = EX_MEM[69];
  assign mem_write  = EX_MEM[70];
  assign reg_write  = EX_MEM[71];
  assign mem_to_reg = EX_MEM[73:72];
  assign pc_plus4   = EX_MEM[105:74];
  assign lu_data    = EX_MEM[137:106];
  assign lu_op      = EX_MEM[138];

  assign access = mem_read | mem_write;

  function automatic logic [31:0] select_data(
    input logic        sel_lu,
    input logic [1:0]  sel_src,
    input logic [31:0] alu_val,
    input logic [31:0] mem_val,
    input logic [31:0] pc_val,
    input logic [31:0] lu_val
  );
    logic [31:0] result;
    result = 32'h0;
    if (sel_lu) begin
      result = lu_val;
    end else begin
      case (sel_src)
        2'b00:   result = alu_val;
        2'b01:   result = mem_val;
        2'b10:   result = pc_val;
        default: result = 32'h0;
      endcase
    end
    return result;
  endfunction

  // Forwarding cannot wait for memory, so the load slot carries the address instead.
  assign fwd_data = select_data(lu_op, mem_to_reg, alu_result, alu_result, pc_plus4, lu_data);
  assign wb_data  = select_data(lu_op, mem_to_reg, alu_result, rdata, pc_plus4, lu_data);

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    issue      = 1'b0;
    ack_seen   = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall      = 1'b1;
          issue      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack) begin
          ack_seen   = 1'b1;
          state_next = DONE;
        end else if (count == COUNT_LAST) begin
          timed_out  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= mem_write;
      mem_addr  <= alu_result;
      mem_wdata <= store_data;
    end else if (ack_seen || timed_out) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      count <= 8'h0;
    end else if (issue) begin
      count <= 8'h0;
    end else if (state == REQ && !mem_ack) begin
      count <= count + 8'd1;
    end
  end

  // A write completes with no data; a timeout returns zero and latches the error.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rdata   <= 32'h0;
      bus_err <= 1'b0;
    end else if (ack_seen) begin
      rdata <= mem_we ? 32'h0 : mem_rdata;
    end else if (timed_out) begin
      rdata   <= 32'h0;
      bus_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      MEM_WB <= 38'h0;
    end else if (stall) begin
      MEM_WB <= 38'h0;
    end else begin
      MEM_WB <= {reg_write, write_reg, wb_data};
    end
  end

  // The request line mirrors the REQ state, and the port fields never move mid-request.
  a_req_matches_state: assert property (
    @(posedge clk) disable iff (!reset_b) mem_req == (state == REQ)
  );
  a_port_stable: assert property (
    @(posedge clk) disable iff (!reset_b)
      (state == REQ) |=> ($stable(mem_addr) && $stable(mem_wdata) && $stable(mem_we))
  );

endmodule
